// File: rtl/num_splitter.sv
// num_splitter: expands a packed {sign, mantissa, exp} number into digit/dot/minus tokens.
// Define NUM_SPLITTER_TRIM_ZEROS_EN to drop trailing zero fractional digits.
module num_splitter #(
  parameter int depth = 16,
  parameter int width = 8,
  parameter int newWidth = 42,
  parameter logic [width-1:0] DOT_TOK = 8'hDD,
  parameter logic [width-1:0] NEG_TOK = 8'hBB
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [newWidth-1:0]               numIn,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow,
  output logic [$clog2(depth+1)-1:0]        size,
  output logic [depth-1:0][width-1:0]       memOut
);
  localparam int SW = $clog2(depth+1);
  localparam int NW = $clog2(depth+2);
  localparam int DW = $clog2(depth);
  localparam int MW = newWidth - 8;

  typedef enum logic [1:0] {IDLE, SPLIT, CHECK, EMIT} state_t;

  state_t                       state_q, state_d;
  logic                         sign_q, sign_d;
  logic [MW-1:0]                m_q, m_d;
  logic [6:0]                   f_q, f_d, z_q, z_d;
  logic [NW-1:0]                n_q, n_d;
  logic [SW-1:0]                idx_q, idx_d;
  logic [7:0]                   len_q, len_d;
  logic [depth-1:0][3:0]        dig_q, dig_d;
  logic [depth-1:0][width-1:0]  mem_q, mem_d;
  logic                         busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [SW-1:0]                size_q, size_d;
  logic [NW-1:0]                t_c;

  logic                         mz;
  logic [6:0]                   ex;
  logic [MW-1:0]                m_div;
  logic [3:0]                   m_mod;
  logic [6:0]                   fe;
  logic [7:0]                   len_c, ni, j, jf;
  logic                         int_sel, frac_sel, dot_sel;
  logic [DW-1:0]                slot;
  logic [width-1:0]             tok;

`ifdef NUM_SPLITTER_TRIM_ZEROS_EN
  logic [NW-1:0]                t_q, t_d;
  logic                         tz_q, tz_d;
  assign t_c = t_q;
`else
  assign t_c = '0;
`endif

  assign mz    = numIn[newWidth-2:7] == '0;
  assign ex    = numIn[6:0];
  assign m_div = m_q / MW'(10);
  assign m_mod = 4'(m_q % MW'(10));

  // Token selection for write index idx: [NEG] int digits [DOT] frac digits zeros
  assign fe       = f_q - 7'(t_c);
  assign len_c    = 8'(sign_q) + 8'(n_q) - 8'(t_c) + 8'(fe != '0) + 8'(z_q);
  assign ni       = 8'(n_q) - 8'(f_q);
  assign j        = 8'(idx_q) - 8'(sign_q);
  assign jf       = j - ni - 8'(fe != '0);
  assign int_sel  = j < ni;
  assign frac_sel = jf < 8'(fe);
  assign dot_sel  = fe != '0 && j == ni;
  assign slot     = int_sel ? DW'(8'(n_q) - 8'd1 - j) : DW'(8'(f_q) - 8'd1 - jf);
  assign tok      = (sign_q && idx_q == '0) ? NEG_TOK :
                    (int_sel || frac_sel)   ? width'(dig_q[slot]) :
                    dot_sel                 ? DOT_TOK : '0;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    m_d     = m_q;
    f_d     = f_q;
    z_d     = z_q;
    n_d     = n_q;
    idx_d   = idx_q;
    len_d   = len_q;
    dig_d   = dig_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    size_d  = size_q;
`ifdef NUM_SPLITTER_TRIM_ZEROS_EN
    t_d     = t_q;
    tz_d    = tz_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        sign_d  = numIn[newWidth-1] & ~mz;
        m_d     = numIn[newWidth-2:7];
        f_d     = (mz | ~ex[6]) ? '0 : 7'(-ex);
        z_d     = (mz | ex[6]) ? '0 : ex;
        n_d     = '0;
        busy_d  = 1'b1;
        ovf_d   = 1'b0;
        size_d  = '0;
        state_d = SPLIT;
`ifdef NUM_SPLITTER_TRIM_ZEROS_EN
        t_d     = '0;
        tz_d    = 1'b1;
`endif
      end
      SPLIT: if (int'(n_q) >= depth) begin
        ovf_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end else begin
        dig_d[n_q[DW-1:0]] = m_mod;
        n_d = n_q + NW'(1);
        m_d = m_div;
        // n >= f keeps at least one integer digit, so a leading 0 precedes the dot
        if (m_div == '0 && 8'(n_q) >= 8'(f_q)) state_d = CHECK;
`ifdef NUM_SPLITTER_TRIM_ZEROS_EN
        if (tz_q && m_mod == '0 && 8'(n_q) < 8'(f_q)) t_d = t_q + NW'(1);
        else tz_d = 1'b0;
`endif
      end
      CHECK: if (len_c > 8'(depth)) begin
        ovf_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end else begin
        idx_d   = '0;
        len_d   = len_c;
        state_d = EMIT;
      end
      EMIT: begin
        mem_d[idx_q[DW-1:0]] = tok;
        idx_d = idx_q + SW'(1);
        if (8'(idx_q) == len_q - 8'd1) begin
          size_d  = SW'(len_q);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      m_q     <= '0;
      f_q     <= '0;
      z_q     <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      dig_q   <= '0;
      mem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      size_q  <= '0;
`ifdef NUM_SPLITTER_TRIM_ZEROS_EN
      t_q     <= '0;
      tz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      m_q     <= m_d;
      f_q     <= f_d;
      z_q     <= z_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      dig_q   <= dig_d;
      mem_q   <= mem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      size_q  <= size_d;
`ifdef NUM_SPLITTER_TRIM_ZEROS_EN
      t_q     <= t_d;
      tz_q    <= tz_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign size     = size_q;
  assign memOut   = mem_q;
endmodule

// File: tb/tb_num_splitter.sv
// tb_num_splitter: directed token-table checks for num_splitter, plus busy-start and async-reset sequences.
module tb_num_splitter;
  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [41:0]       numIn = '0;
  logic              busy, done, overflow;
  logic [4:0]        size;
  logic [15:0][7:0]  memOut;
  logic [15:0][7:0]  model = '0;
  int                checks = 0;
  int                errors = 0;

  typedef struct {
    string       name;
    logic [41:0] num;
    int          len;
    bit          ovf;
    int          lat;
    logic [63:0] toks;
  } vec_t;
  vec_t vq[$];

  num_splitter dut (
    .clock(clock), .reset(reset), .start(start), .numIn(numIn),
    .busy(busy), .done(done), .overflow(overflow), .size(size), .memOut(memOut)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [41:0] pk(input bit s, input logic [33:0] m, input int e);
    return {s, m, 7'(e)};
  endfunction

  task automatic add(input string nm, input logic [41:0] num, input int len, input bit ovf,
                     input int lat, input logic [63:0] toks);
    vec_t v;
    v.name = nm; v.num = num; v.len = len; v.ovf = ovf; v.lat = lat; v.toks = toks;
    vq.push_back(v);
  endtask

  task automatic launch(input logic [41:0] num);
    @(negedge clock);
    numIn = num;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    launch(v.num);
    chk({v.name, " busy"}, busy, 1);
    wait_done(lat);
    chk({v.name, " latency"}, lat, v.lat);
    chk({v.name, " overflow"}, overflow, v.ovf);
    chk({v.name, " busy low"}, busy, 0);
    if (!v.ovf)
      for (int k = 0; k < v.len; k++) model[k] = v.toks[63-8*k -: 8];
    chk({v.name, " size"}, size, v.ovf ? 0 : v.len);
    chk({v.name, " memOut"}, memOut, model);
    @(negedge clock);
    chk({v.name, " done pulse"}, done, 0);
    chk({v.name, " overflow held"}, overflow, v.ovf);
  endtask

  initial begin
    int cnt;
    add("n12345e-2", pk(0, 12345, -2), 6, 0, 12, 64'h010203DD0405_0000);
    add("neg5e-3",   pk(1, 5, -3),     6, 0, 11, 64'hBB00DD000005_0000);
    add("negzero",   pk(1, 0, -4),     1, 0, 3,  64'h0);
    add("n7e3",      pk(0, 7, 3),      4, 0, 6,  64'h07000000_00000000);
    add("ovf_check", pk(0, 1, 20),     0, 1, 2,  64'h0);
    add("ovf_split", pk(0, 1, -20),    0, 1, 17, 64'h0);
`ifdef NUM_SPLITTER_TRIM_ZEROS_EN
    add("n1500e-3",  pk(0, 1500, -3),  3, 0, 8,  64'h01DD05_0000000000);
`else
    add("n1500e-3",  pk(0, 1500, -3),  5, 0, 10, 64'h01DD050000_000000);
`endif
    add("neg987",    pk(1, 987, 0),    4, 0, 8,  64'hBB090807_00000000);
    add("zero_e5",   pk(0, 0, 5),      1, 0, 3,  64'h0);
    add("n42e-1",    pk(0, 42, -1),    3, 0, 6,  64'h04DD02_0000000000);
    add("n5e-1",     pk(0, 5, -1),     3, 0, 6,  64'h00DD05_0000000000);

    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset overflow", overflow, 0);
    chk("reset size", size, 0);
    chk("reset memOut", memOut, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    foreach (vq[i]) run_vec(vq[i]);

    // second start while busy must be ignored
    launch(pk(0, 7, 3));
    chk("dbl busy", busy, 1);
    @(negedge clock);
    numIn = pk(0, 1, 20);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (done) cnt++;
    end
    chk("dbl done count", cnt, 1);
    chk("dbl overflow", overflow, 0);
    chk("dbl size", size, 4);
    model[0] = 8'h07; model[1] = 8'h00; model[2] = 8'h00; model[3] = 8'h00;
    chk("dbl memOut", memOut, model);

    // asynchronous reset in the middle of EMIT
    launch(pk(0, 12345, -2));
    repeat (8) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("areset busy", busy, 0);
    chk("areset done", done, 0);
    chk("areset overflow", overflow, 0);
    chk("areset size", size, 0);
    chk("areset memOut", memOut, 0);
    model = '0;
    @(negedge clock);
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (done) cnt++;
    end
    chk("areset no done", cnt, 0);
    run_vec(vq[9]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/num_splitter.md
Name: num_splitter

Overview:
- Inverse of the token-to-number builder. Takes one packed number {sign, mantissa[33:0], exp[6:0]} and expands it into a key-token array for the display/readback path.
- Output tokens: digits 8'h00..8'h09, DOT_TOK for the decimal point, NEG_TOK for the minus sign.
- Sits after the evaluator. Fills a memOut array plus size, with a done pulse, matching the token-array interface used upstream.

Parameters:
- depth, 16, number of memOut entries (maximum output token count).
- width, 8, token width.
- newWidth, 42, packed number width = 1 + 34 + 7.
- DOT_TOK, 8'hDD, decimal-point token.
- NEG_TOK, 8'hBB, minus-sign token.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- numIn  in  newWidth  packed number {sign, mantissa[33:0], signed exp[6:0]}.
- busy  out  1  high from the start-accept edge until the edge that returns to IDLE.
- done  out  1  one-cycle pulse; conversion finished.
- overflow  out  1  result did not fit; valid with done, held until the next accepted start.
- size  out  $clog2(depth+1)  number of valid memOut tokens; valid with done.
- memOut  out  width x depth  token array; index 0 is the most significant token.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, done, overflow, size and every memOut entry = 0.
  - All internal registers cleared.
  - Applies mid-conversion too: the conversion is abandoned and no done pulse is issued.
- Value semantics: mantissa * 10^exp. Define f = (exp<0) ? -exp : 0 and z = (exp>0) ? exp : 0.
- IDLE:
  - start=1 latches numIn. Same edge: busy<=1, overflow<=0, size<=0, digit count n<=0, go to SPLIT.
  - Zero normalization: mantissa==0 forces sign=0 and f=z=0.
  - start while busy is ignored.
- SPLIT, one digit per cycle:
  - Write m%10 into digit buffer slot n, then n<=n+1 and m<=m/10.
  - Leave to CHECK when m/10==0 and n+1 >= f+1. This guarantees a leading "0" before the dot.
  - If n+1 > depth: overflow<=1, done<=1, busy<=0, return to IDLE. memOut and size are unchanged.
- CHECK, one cycle:
  - L = sign + n + (f>0) + z.
  - If L > depth: overflow<=1, done<=1, busy<=0, go to IDLE; memOut untouched.
  - Otherwise reset the write index to 0 and go to EMIT.
- EMIT, one token per cycle, written to memOut[idx] in this order:
  - NEG_TOK if sign=1.
  - The n-f integer digits, most significant first.
  - DOT_TOK if f>0.
  - The f fractional digits.
  - z tokens of 8'h00.
- EMIT exit: on the edge writing token L-1, size<=L, done<=1, busy<=0, go to IDLE.
- memOut entries at index >= L keep their previous contents.
- Latency: with start accepted at edge 0, done is high in the cycle after edge n+1+L. On overflow in CHECK, done follows edge n+1.
- done and busy=0 assert on the same edge.
- Arithmetic: /10 and %10 are combinational on the 34-bit working register. The n counter is sized to reach depth+1.

Optional Feature:
- Macro: NUM_SPLITTER_TRIM_ZEROS_EN.
- Defined:
  - During SPLIT, count t = trailing zero digits from the LSB, limited to the first f digits.
  - CHECK uses f' = f - t and n' = n - t, dropping the dot if f'=0.
  - EMIT skips the trimmed digits.
  - The SPLIT overflow threshold still uses the untrimmed n.
- Undefined: all f fractional digits are emitted, including trailing zeros.

Test Plan:
- numIn={0,12345,-2}, start pulse -> memOut[0..5]=01 02 03 DD 04 05, size=6, overflow=0. done high in the cycle after edge 12; busy high for edges 0..11.
- numIn={1,5,-3} -> BB 00 DD 00 00 05, size=6. numIn={1,0,-4} -> 00, size=1 (sign and dot suppressed).
- numIn={0,7,3} -> 07 00 00 00, size=4. Issue a second start while busy -> ignored; exactly one done pulse.
- numIn={0,1,20} -> L=21>16 -> overflow=1, size=0, memOut unchanged from the prior run. numIn={0,1,-20} -> SPLIT overflow after 17 digits, overflow=1.
- Drive reset=0 asynchronously midway through EMIT -> outputs cleared immediately, no done pulse. A later start converts normally.
- numIn={0,1500,-3}:
  - With NUM_SPLITTER_TRIM_ZEROS_EN -> 01 DD 05, size=3.
  - Without it -> 01 DD 05 00 00, size=5.
